prefetch_queue: RTL

Parametrised instruction prefetch unit sitting between the memory bus and the opcode/ModRM/offset/immediate decoder. It replaces demand fetching by the decoder state machine with a byte-wide ring queue. The queue is filled autonomously with aligned word or single-byte bus reads at the fetch pointer CS:IP. The decoder consumes 0–2 bytes per cycle. A flush reloads CS:IP on jumps and far transfers.

---
 rtl/prefetch_pkg.sv | 18 +
 rtl/byte_ring.sv | 48 ++++
 rtl/prefetch_queue.sv | 133 +++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared state encoding, reset vector and address helper for the prefetch queue
package prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [15:0] RST_CS = 16'hFFFF;
  localparam logic [15:0] RST_IP = 16'h0000;

  // 20-bit real-mode linear address; the carry out of bit 19 is dropped
  function automatic logic [19:0] lin_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/byte_ring.sv
// rtl/byte_ring.sv - byte-wide ring buffer with 0-2 byte write and 0-2 byte read per cycle
module byte_ring #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic [1:0]    wr_cnt_i,
  input  logic [15:0]   wr_data_i,
  input  logic [1:0]    rd_cnt_i,
  output logic [15:0]   rd_data_o,
  output logic [LW-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [LW-1:0] level_q;
  logic [AW-1:0] head_nx, tail_nx;

  assign head_nx = head_q + AW'(1);
  assign tail_nx = tail_q + AW'(1);

  // Callers guarantee writes never exceed free space and reads never exceed level
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else if (clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      if (wr_cnt_i != 2'd0) mem_q[tail_q]  <= wr_data_i[7:0];
      if (wr_cnt_i == 2'd2) mem_q[tail_nx] <= wr_data_i[15:8];
      tail_q  <= tail_q + AW'(wr_cnt_i);
      head_q  <= head_q + AW'(rd_cnt_i);
      level_q <= level_q + LW'(wr_cnt_i) - LW'(rd_cnt_i);
    end
  end

  assign rd_data_o = {mem_q[head_nx], mem_q[head_q]};
  assign level_o   = level_q;

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - instruction prefetch unit: autonomous bus fetch FSM feeding a byte ring
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [15:0]   new_cs,
  input  logic [15:0]   new_ip,
  output logic          mem_req,
  output logic [19:0]   mem_addr,
  output logic          mem_byte,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  input  logic [1:0]    rd_cnt,
  output logic [15:0]   q_data,
  output logic [LW-1:0] q_level,
  output logic [15:0]   head_cs,
  output logic [15:0]   head_ip
);

  state_e        state_q;
  logic [15:0]   fcs_q, fip_q, hcs_q, hip_q;
  logic          mem_req_q, mem_byte_q;
  logic [19:0]   mem_addr_q;

  logic [LW-1:0] level;
  logic [LW-1:0] free;
  logic [1:0]    inflight, rd_req, rd_eff, wr_cnt;
  logic [15:0]   wr_data;

  // Bytes of the outstanding request count against free space; drained data never lands
  always_comb begin
    inflight = 2'd0;
    if (state_q == ST_BUSY) inflight = mem_byte_q ? 2'd1 : 2'd2;
    free   = LW'(DEPTH) - level - LW'(inflight);
    rd_req = (rd_cnt == 2'd3) ? 2'd2 : rd_cnt;
    rd_eff = (LW'(rd_req) > level) ? level[1:0] : rd_req;
    if (flush) rd_eff = 2'd0;
    wr_cnt = 2'd0;
    if (state_q == ST_BUSY && mem_ack && !flush) wr_cnt = inflight;
    wr_data = mem_byte_q ? {8'h00, mem_data[7:0]} : mem_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fcs_q      <= RST_CS;
      fip_q      <= RST_IP;
      mem_req_q  <= 1'b0;
      mem_byte_q <= 1'b0;
      mem_addr_q <= lin_addr(RST_CS, RST_IP);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            fcs_q <= new_cs;
            fip_q <= new_ip;
          end else if (free != '0) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= lin_addr(fcs_q, fip_q);
            mem_byte_q <= fip_q[0] | (free == LW'(1));
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            fcs_q <= new_cs;
            fip_q <= new_ip;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              state_q   <= ST_DRAIN;
            end
          end else if (mem_ack) begin
            fip_q     <= fip_q + (mem_byte_q ? 16'd1 : 16'd2);
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (flush) begin
            fcs_q <= new_cs;
            fip_q <= new_ip;
          end
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcs_q <= RST_CS;
      hip_q <= RST_IP;
    end else if (flush) begin
      hcs_q <= new_cs;
      hip_q <= new_ip;
    end else begin
      hip_q <= hip_q + {14'h0000, rd_eff};
    end
  end

  byte_ring #(.DEPTH(DEPTH), .LW(LW)) u_ring (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (flush),
    .wr_cnt_i  (wr_cnt),
    .wr_data_i (wr_data),
    .rd_cnt_i  (rd_eff),
    .rd_data_o (q_data),
    .level_o   (level)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign mem_byte = mem_byte_q;
  assign q_level  = level;
  assign head_cs  = hcs_q;
  assign head_ip  = hip_q;

endmodule
